// File: rtl/tr_seq_pkg.sv
// tr_seq_pkg
// Shared types for the LNA transmit/receive switch sequencer.
//   state_t : sequencer phase (IDLE, GUARD, SETTLE, ACTIVE)
//   dir_t   : which switch path is being sequenced (DIR_RX, DIR_TX)
//   drives_enable() : true in the phases where the selected enable is high
package tr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    SETTLE = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dir_t;

  // The selected gate is driven from the first SETTLE cycle until ACTIVE ends.
  function automatic logic drives_enable(input state_t s);
    return (s == SETTLE) || (s == ACTIVE);
  endfunction

endpackage

// File: rtl/tr_seq_timer.sv
// tr_seq_timer
// Loadable down-counter shared by the dead-time, settle and transmit-watchdog
// phases of the sequencer.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (takes priority over en)
//   load_val  : value to load; a phase of N cycles loads N-1
//   en        : count down by one per cycle, holding at zero
//   zero      : count is zero, i.e. the current cycle is the last of the phase
module tr_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tr_switch_sequencer.sv
// tr_switch_sequencer
// Sequencing controller for the LNA transmit/receive switch. Arbitrates
// transmit/receive requests and drives the switch gate controls with
// break-before-make dead time, settle time before granting, alternating
// fairness and a transmit-duration watchdog.
//
// Ports:
//   clk, rst        : clock; synchronous active-high reset
//   tx_req          : level, MAC wants to transmit
//   tx_done         : 1-cycle pulse, transmit burst finished (ignored unless TX ACTIVE)
//   rx_req          : level, MAC wants to listen
//   fault_clr       : pulse, clears fault (a same-cycle watchdog event wins)
//   enable_transmit : switch EnableTransmit gate (registered)
//   enable_receive  : switch EnableReceive gate (registered)
//   tx_grant        : transmit path settled and usable (registered)
//   rx_grant        : receive path settled and usable (registered)
//   busy            : sequencer not in IDLE (registered)
//   fault           : sticky transmit-watchdog fault (registered)
//   state_dbg       : current FSM state, for debug/checkers
//
// Request protocol: there is no valid/ready pair. tx_req/rx_req are levels
// held for as long as the path is wanted; the matching grant is the "ready"
// indication and stays high only while its request stays high. Dropping a
// request during GUARD or SETTLE abandons the sequence back to IDLE.
//
// All outputs are Moore-decoded from the next state and registered, so they
// change on the same edge as the state register.
module tr_switch_sequencer
  import tr_seq_pkg::*;
#(
  parameter int DEAD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_TX_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   tx_req,
  input  logic   tx_done,
  input  logic   rx_req,
  input  logic   fault_clr,
  output logic   enable_transmit,
  output logic   enable_receive,
  output logic   tx_grant,
  output logic   rx_grant,
  output logic   busy,
  output logic   fault,
  output state_t state_dbg
);

  // A phase of N cycles loads N-1: the phase ends on the cycle the timer is zero.
  localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LOAD     = CNT_W'(MAX_TX_CYCLES - 1);

  state_t           state, state_n;
  dir_t             dir, dir_n;
  logic             last_was_tx, last_n;
  logic             fault_n;
  logic             wd_fire;
  logic             tx_ok;
  logic             dir_req;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_zero;

  tr_seq_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  // Fault only blocks new transmit arbitration (and RX preemption by TX).
  assign tx_ok   = tx_req && !fault;
  // Request belonging to the path currently being sequenced.
  assign dir_req = (dir == DIR_TX) ? tx_req : rx_req;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    last_n  = last_was_tx;
    wd_fire = 1'b0;
    case (state)
      IDLE: begin
        // TX wins unless RX is also waiting and TX went last.
        if (tx_ok && (!rx_req || !last_was_tx)) begin
          state_n = GUARD;
          dir_n   = DIR_TX;
        end else if (rx_req) begin
          state_n = GUARD;
          dir_n   = DIR_RX;
        end
      end
      GUARD, SETTLE: begin
        if (!dir_req) begin
          state_n = IDLE;
        end else if (tmr_zero) begin
          state_n = (state == GUARD) ? SETTLE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (dir == DIR_TX) begin
          if (tx_done || !tx_req || tmr_zero) begin
            last_n  = 1'b1;
            // A burst that completes on its last allowed cycle is not a fault.
            wd_fire = tmr_zero && !tx_done;
            if (rx_req) begin
              state_n = GUARD;
              dir_n   = DIR_RX;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          if (tx_ok) begin
            state_n = GUARD;
            dir_n   = DIR_TX;
            last_n  = 1'b0;
          end else if (!rx_req) begin
            state_n = IDLE;
            last_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Watchdog set has priority over clear.
    fault_n = fault;
    if (fault_clr) fault_n = 1'b0;
    if (wd_fire)   fault_n = 1'b1;
  end

  // Every phase entry reloads the shared timer with that phase's length.
  always_comb begin
    tmr_load     = (state_n != state);
    tmr_load_val = '0;
    case (state_n)
      GUARD:   tmr_load_val = DEAD_LOAD;
      SETTLE:  tmr_load_val = SETTLE_LOAD;
      ACTIVE:  tmr_load_val = WD_LOAD;
      default: tmr_load_val = '0;
    endcase
    tmr_en = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      dir             <= DIR_RX;
      last_was_tx     <= 1'b0;
      fault           <= 1'b0;
      enable_transmit <= 1'b0;
      enable_receive  <= 1'b0;
      tx_grant        <= 1'b0;
      rx_grant        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      dir             <= dir_n;
      last_was_tx     <= last_n;
      fault           <= fault_n;
      enable_transmit <= drives_enable(state_n) && (dir_n == DIR_TX);
      enable_receive  <= drives_enable(state_n) && (dir_n == DIR_RX);
      tx_grant        <= (state_n == ACTIVE) && (dir_n == DIR_TX);
      rx_grant        <= (state_n == ACTIVE) && (dir_n == DIR_RX);
      busy            <= (state_n != IDLE);
    end
  end

  assign state_dbg = state;

endmodule
